// File: rtl/reg_display_driver.sv
// Seven-segment driver for the register file's display word: registers a changed value,
// converts it to BCD one bit per cycle (double-dabble) and latches the segment patterns.
module reg_display_driver #(
    parameter int WIDTH    = 32,
    parameter int DIGITS   = 8,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [WIDTH-1:0]    value,
    output logic [7*DIGITS-1:0] hex_n,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic                valid
);

    function automatic logic [63:0] pow10_minus1(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r - 64'd1;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    localparam int               BW        = 4 * DIGITS;
    localparam int               CW        = $clog2(WIDTH + 1);
    localparam logic [63:0]      MAXV64    = pow10_minus1(DIGITS);
    localparam logic [WIDTH-1:0] MAXV      = MAXV64[WIDTH-1:0];
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    state_t              state;
    logic [WIDTH-1:0]    last;
    logic [WIDTH-1:0]    shreg;
    logic [BW-1:0]       bcd;
    logic [BW-1:0]       bcd_adj;
    logic [CW-1:0]       cnt;
    logic                ovf_p;
    logic                force_conv;
    logic [7*DIGITS-1:0] hex_next;
    logic [3:0]          digit;
    logic                seen_nz;

    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    // Walk from the top digit down so leading zeros can be blanked until the first nonzero digit.
    always_comb begin
        hex_next = '1;
        seen_nz  = 1'b0;
        digit    = 4'd0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            digit = bcd[4*k +: 4];
            if (digit != 4'd0) seen_nz = 1'b1;
            if (ovf_p)
                hex_next[7*k +: 7] = 7'h3F;
            else if (BLANK_LZ && !seen_nz && k != 0)
                hex_next[7*k +: 7] = 7'h7F;
            else
                hex_next[7*k +: 7] = seg7(digit);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            hex_n      <= '1;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            valid      <= 1'b0;
            last       <= '0;
            shreg      <= '0;
            bcd        <= '0;
            cnt        <= '0;
            ovf_p      <= 1'b0;
            force_conv <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (value != last || force_conv) begin
                        last       <= value;
                        shreg      <= value;
                        bcd        <= '0;
                        cnt        <= '0;
                        ovf_p      <= (value > MAXV);
                        force_conv <= 1'b0;
                        busy       <= 1'b1;
                        state      <= CONVERT;
                    end
                end
                CONVERT: begin
                    // Bits shifted out of the top nibble are dropped; overflow masks that case.
                    {bcd, shreg} <= {bcd_adj, shreg} << 1;
                    cnt          <= cnt + 1'b1;
                    if (cnt == LAST_ITER) state <= UPDATE;
                end
                UPDATE: begin
                    hex_n    <= hex_next;
                    overflow <= ovf_p;
                    done     <= 1'b1;
                    valid    <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_display_driver.sv
// Bench for reg_display_driver: a decimal reference model feeds a scoreboard that is
// checked on every done pulse; scenario tasks add their own timing and constant checks.
module tb_reg_display_driver;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 8;
    localparam int LAT    = WIDTH + 2;

    logic                clock;
    logic                reset;
    logic [WIDTH-1:0]    value;
    logic [7*DIGITS-1:0] hex_n;
    logic                busy;
    logic                done;
    logic                overflow;
    logic                valid;
    logic [7*DIGITS-1:0] hex_z;
    logic                busy_z;
    logic                done_z;
    logic                overflow_z;
    logic                valid_z;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [WIDTH-1:0]    v;
        logic [7*DIGITS-1:0] hex_b;
        logic [7*DIGITS-1:0] hex_z;
        logic                ovf;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    reg_display_driver #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(1'b1)) dut (
        .clock(clock), .reset(reset), .value(value), .hex_n(hex_n),
        .busy(busy), .done(done), .overflow(overflow), .valid(valid)
    );

    reg_display_driver #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(1'b0)) dut_z (
        .clock(clock), .reset(reset), .value(value), .hex_n(hex_z),
        .busy(busy_z), .done(done_z), .overflow(overflow_z), .valid(valid_z)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'h40;  4'd1: s = 7'h79;  4'd2: s = 7'h24;  4'd3: s = 7'h30;
            4'd4: s = 7'h19;  4'd5: s = 7'h12;  4'd6: s = 7'h02;  4'd7: s = 7'h78;
            4'd8: s = 7'h00;  4'd9: s = 7'h10;  default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Reference uses plain decimal division, independent of the double-dabble datapath.
    function automatic logic [7*DIGITS-1:0] model_hex(input logic [WIDTH-1:0] v, input bit blank);
        logic [7*DIGITS-1:0] h;
        longint unsigned     vv;
        longint unsigned     p;
        h  = '1;
        vv = longint'(v);
        if (vv > 64'd99999999) return {DIGITS{7'h3F}};
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            if (blank && k > 0 && vv < p) h[7*k +: 7] = 7'h7F;
            else h[7*k +: 7] = seg_of(4'((vv / p) % 10));
            p = p * 10;
        end
        return h;
    endfunction

    task automatic push_expected(input logic [WIDTH-1:0] v);
        exp_t e;
        e.v     = v;
        e.hex_b = model_hex(v, 1'b1);
        e.hex_z = model_hex(v, 1'b0);
        e.ovf   = (longint'(v) > 64'd99999999);
        sb.push_back(e);
    endtask

    task automatic wait_done(input int budget, output int edges, output int busy_cycles);
        int i;
        i           = 0;
        edges       = -1;
        busy_cycles = 0;
        while (edges < 0 && i < budget) begin
            @(negedge clock);
            i++;
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) edges = i;
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_done: got done=1 hex=%h expected no update", hex_n);
            end else begin
                cur = sb.pop_front();
                total++;
                if (hex_n !== cur.hex_b) begin
                    bad++;
                    $display("[TB] FAIL sb_hex(v=%0d): got %h expected %h", cur.v, hex_n, cur.hex_b);
                end
                total++;
                if (hex_z !== cur.hex_z) begin
                    bad++;
                    $display("[TB] FAIL sb_hex_nolz(v=%0d): got %h expected %h", cur.v, hex_z, cur.hex_z);
                end
                total++;
                if (overflow !== cur.ovf) begin
                    bad++;
                    $display("[TB] FAIL sb_overflow(v=%0d): got %b expected %b", cur.v, overflow, cur.ovf);
                end
                total++;
                if (valid !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL sb_valid(v=%0d): got %b expected 1", cur.v, valid);
                end
            end
        end
    end

    task automatic test_reset();
        int edges;
        int bc;
        reset = 1'b1;
        value = '0;
        repeat (3) @(negedge clock);
        total++;
        if ({hex_n, busy, done, overflow, valid} !== {{DIGITS{7'h7F}}, 4'b0000}) begin
            bad++;
            $display("[TB] FAIL reset_state: got hex=%h b=%b d=%b o=%b v=%b expected all 7F and 0000",
                     hex_n, busy, done, overflow, valid);
        end
        reset = 1'b0;
        push_expected('0);
        wait_done(100, edges, bc);
        total++;
        if (edges !== LAT) begin
            bad++;
            $display("[TB] FAIL reset_forced_latency: got %0d expected %0d", edges, LAT);
        end
        total++;
        if (hex_n !== {{(DIGITS-1){7'h7F}}, 7'h40}) begin
            bad++;
            $display("[TB] FAIL reset_zero_display: got %h expected %h", hex_n, {{(DIGITS-1){7'h7F}}, 7'h40});
        end
    endtask

    task automatic test_conversion();
        int edges;
        int bc;
        value = 32'd12345678;
        push_expected(value);
        wait_done(100, edges, bc);
        total++;
        if (edges !== LAT) begin
            bad++;
            $display("[TB] FAIL conv_latency: got %0d expected %0d", edges, LAT);
        end
        total++;
        if (bc !== WIDTH + 1) begin
            bad++;
            $display("[TB] FAIL conv_busy_cycles: got %0d expected %0d", bc, WIDTH + 1);
        end
        total++;
        if (hex_n !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}) begin
            bad++;
            $display("[TB] FAIL conv_digits: got %h expected 79243019120278 00", hex_n);
        end
        @(negedge clock);
        total++;
        if ({done, busy} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL conv_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_overflow();
        int edges;
        int bc;
        value = 32'd100000000;
        push_expected(value);
        wait_done(100, edges, bc);
        total++;
        if ({hex_n, overflow} !== {{DIGITS{7'h3F}}, 1'b1}) begin
            bad++;
            $display("[TB] FAIL ovf_dashes: got %h o=%b expected all 3F o=1", hex_n, overflow);
        end
        value = 32'd99999999;
        push_expected(value);
        wait_done(100, edges, bc);
        total++;
        if ({hex_n, overflow} !== {{DIGITS{7'h10}}, 1'b0}) begin
            bad++;
            $display("[TB] FAIL ovf_max_nines: got %h o=%b expected all 10 o=0", hex_n, overflow);
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        int bc;
        value = 32'd5;
        push_expected(value);
        repeat (10) @(negedge clock);
        value = 32'd7;
        push_expected(value);
        wait_done(100, edges, bc);
        total++;
        if (edges !== LAT - 10) begin
            bad++;
            $display("[TB] FAIL b2b_first_done: got %0d expected %0d", edges, LAT - 10);
        end
        wait_done(100, edges, bc);
        total++;
        if (edges !== LAT) begin
            bad++;
            $display("[TB] FAIL b2b_second_latency: got %0d expected %0d", edges, LAT);
        end
    endtask

    task automatic test_reset_abort();
        int edges;
        int bc;
        value = 32'd4321;
        repeat (17) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        total++;
        if ({hex_n, busy, valid, overflow, done} !== {{DIGITS{7'h7F}}, 4'b0000}) begin
            bad++;
            $display("[TB] FAIL abort_state: got hex=%h b=%b v=%b o=%b d=%b expected all 7F and 0000",
                     hex_n, busy, valid, overflow, done);
        end
        reset = 1'b0;
        push_expected(value);
        wait_done(100, edges, bc);
        total++;
        if (edges !== LAT) begin
            bad++;
            $display("[TB] FAIL abort_forced_latency: got %0d expected %0d", edges, LAT);
        end
    endtask

    task automatic test_blanking();
        int edges;
        int bc;
        value = 32'd10;
        push_expected(value);
        wait_done(100, edges, bc);
        total++;
        if (hex_n !== {{(DIGITS-2){7'h7F}}, 7'h79, 7'h40}) begin
            bad++;
            $display("[TB] FAIL blank_lz1: got %h expected %h", hex_n, {{(DIGITS-2){7'h7F}}, 7'h79, 7'h40});
        end
        total++;
        if (hex_z !== {{(DIGITS-2){7'h40}}, 7'h79, 7'h40}) begin
            bad++;
            $display("[TB] FAIL blank_lz0: got %h expected %h", hex_z, {{(DIGITS-2){7'h40}}, 7'h79, 7'h40});
        end
    endtask

    task automatic test_no_change();
        int bc;
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (busy === 1'b1) bc++;
        end
        total++;
        if (bc !== 0) begin
            bad++;
            $display("[TB] FAIL no_change_busy: got %0d busy cycles expected 0", bc);
        end
    endtask

    task automatic test_max_value();
        int edges;
        int bc;
        value = 32'hFFFF_FFFF;
        push_expected(value);
        wait_done(100, edges, bc);
        total++;
        if (edges !== LAT) begin
            bad++;
            $display("[TB] FAIL max_latency: got %0d expected %0d", edges, LAT);
        end
        value = 32'd907;
        push_expected(value);
        wait_done(100, edges, bc);
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL max_then_small_ovf: got %b expected 0", overflow);
        end
    endtask

    initial begin
        reset = 1'b1;
        value = '0;
        test_reset();
        test_conversion();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        test_blanking();
        test_no_change();
        test_max_value();
        repeat (3) @(negedge clock);
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("[TB] FAIL sb_drained: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
